// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; BUSY stalls dependents.
// Define MDU_MADD_EN to build the madd/maddu accumulate path into {HI,LO}.
module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        START,
    input  logic [1:0]  MDU_OP,
    input  logic        madd,
    input  logic        HiLo,
    input  logic        WRITE_ENABLED,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic [31:0] OUT
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic        state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo;
    logic [63:0] pend;
    logic        pend_wr;
    logic [63:0] commit_val;

    logic        sgn, is_div, neg_a, neg_b;
    logic [63:0] ext_a, ext_b, product;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

    // One multiplier serves both mult and multu: sign-extend only for the signed op.
    always_comb begin
        sgn     = ~MDU_OP[0];
        is_div  = MDU_OP[1];
        ext_a   = {{32{sgn & A[31]}}, A};
        ext_b   = {{32{sgn & B[31]}}, B};
        product = ext_a * ext_b;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        neg_a = sgn & A[31];
        neg_b = sgn & B[31];
        mag_a = neg_a ? -A : A;
        mag_b = neg_b ? -B : B;
        q_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        r_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        quo   = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem   = neg_a ? -r_mag : r_mag;
    end

`ifdef MDU_MADD_EN
    logic pend_acc;
    // Accumulate against HI/LO as they stand at commit time.
    assign commit_val = pend_acc ? ({hi, lo} + pend) : pend;
`else
    logic unused_madd;
    assign unused_madd = madd;
    assign commit_val  = pend;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
`ifdef MDU_MADD_EN
            pend_acc <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pend    <= is_div ? {rem, quo} : product;
                        pend_wr <= ~(is_div && (B == 32'd0));
`ifdef MDU_MADD_EN
                        pend_acc <= madd & ~is_div;
`endif
                        cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state   <= S_RUN;
                    end else if (WRITE_ENABLED) begin
                        if (HiLo) hi <= A;
                        else      lo <= A;
                    end
                end
                default: begin
                    if (cnt <= 4'd1) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                        if (pend_wr) {hi, lo} <= commit_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign BUSY = (state == S_RUN);
    assign OUT  = HiLo ? hi : lo;

endmodule

// File: tb/tb_mdu_core.sv
// Directed + randomized bench for mdu_core against a plain-arithmetic HI/LO model.
module tb_mdu_core;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  MDU_OP = 2'd0;
    logic        madd = 1'b0;
    logic        HiLo = 1'b0;
    logic        WRITE_ENABLED = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        BUSY;
    logic [31:0] OUT;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mdu_core #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .START(START), .MDU_OP(MDU_OP), .madd(madd),
        .HiLo(HiLo), .WRITE_ENABLED(WRITE_ENABLED), .A(A), .B(B), .BUSY(BUSY), .OUT(OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_regs(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        HiLo = 1'b1; #1;
        check({tag, ".hi"}, OUT, ehi);
        HiLo = 1'b0; #1;
        check({tag, ".lo"}, OUT, elo);
    endtask

    // Architectural effect of one completed operation, from the arithmetic rules.
    task automatic model_op(input logic [1:0] op, input logic md, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[1]) begin
            if (op == 2'd0) p = sa * sb;
            else            p = {32'd0, a} * {32'd0, b};
`ifdef MDU_MADD_EN
            if (md) p = p + {mhi, mlo};
`else
            if (md === 1'bx) p = 64'd0;
`endif
            {mhi, mlo} = p;
        end else if (b != 32'd0) begin
            if (op == 2'd2) begin
                mlo = 32'(sa / sb);
                mhi = 32'(sa % sb);
            end else begin
                mlo = a / b;
                mhi = a % b;
            end
        end
    endtask

    task automatic mt(input logic sel, input logic [31:0] val);
        WRITE_ENABLED = 1'b1; HiLo = sel; A = val;
        tick();
        WRITE_ENABLED = 1'b0;
        check("mt.busy", {31'd0, BUSY}, 32'd0);
        if (sel) mhi = val; else mlo = val;
        expect_regs("mt", mhi, mlo);
    endtask

    // intr: 0 none, 1 START during busy, 2 WRITE_ENABLED during busy
    task automatic run_op(input string tag, input logic [1:0] op, input logic md,
                          input logic [31:0] a, input logic [31:0] b,
                          input int intr, input logic we_same);
        int cnt;
        MDU_OP = op; madd = md; A = a; B = b;
        START = 1'b1; WRITE_ENABLED = we_same; HiLo = 1'($urandom_range(0, 1));
        tick();
        START = 1'b0; WRITE_ENABLED = 1'b0;
        model_op(op, md, a, b);
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 2 && intr == 1) begin
                START = 1'b1; MDU_OP = 2'($urandom_range(0, 3)); madd = 1'b1;
                A = $urandom; B = $urandom;
            end else if (cnt == 2 && intr == 2) begin
                WRITE_ENABLED = 1'b1; A = $urandom; HiLo = 1'($urandom_range(0, 1));
            end
            tick();
            START = 1'b0; WRITE_ENABLED = 1'b0;
        end
        check({tag, ".busy_cycles"}, 32'(cnt), op[1] ? 32'(DIV_N) : 32'(MULT_N));
        expect_regs(tag, mhi, mlo);
    endtask

    initial begin
        logic [31:0] specials [6];
        specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'd1;
        specials[3] = 32'h7FFF_FFFF; specials[4] = 32'd0;          specials[5] = 32'hFFFF_FFF9;

        repeat (2) tick();
        check("reset.busy", {31'd0, BUSY}, 32'd0);
        expect_regs("reset", 32'd0, 32'd0);
        reset_n = 1'b1;
        tick();

        run_op("mult", 2'd0, 1'b0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        expect_regs("mult.lit", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 2'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        expect_regs("multu.lit", 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div_neg", 2'd2, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        expect_regs("div_neg.lit", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'd2, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        expect_regs("div_ovf.lit", 32'h0, 32'h8000_0000);
        run_op("div_zero", 2'd2, 1'b0, 32'h1234, 32'd0, 0, 1'b0);
        expect_regs("div_zero.lit", 32'h0, 32'h8000_0000);

        mt(1'b1, 32'h1234_5678);
        expect_regs("mthi.lit", 32'h1234_5678, 32'h8000_0000);

        run_op("start_busy", 2'd0, 1'b0, 32'd3, 32'd4, 1, 1'b0);
        expect_regs("start_busy.lit", 32'd0, 32'd12);
        run_op("we_busy", 2'd3, 1'b0, 32'd100, 32'd7, 2, 1'b0);
        run_op("we_start", 2'd1, 1'b0, 32'd9, 32'd9, 0, 1'b1);

        mt(1'b1, 32'd0);
        mt(1'b0, 32'hFFFF_FFFF);
        run_op("madd", 2'd0, 1'b1, 32'd1, 32'd1, 0, 1'b0);
`ifdef MDU_MADD_EN
        expect_regs("madd.lit", 32'd1, 32'd0);
`else
        expect_regs("madd.lit", 32'd0, 32'd1);
`endif
        run_op("madd_div", 2'd2, 1'b1, 32'd100, 32'd7, 0, 1'b0);
        expect_regs("madd_div.lit", 32'd2, 32'd14);

        // Reset in busy cycle 3 of a divide discards the result.
        MDU_OP = 2'd2; A = 32'd50; B = 32'd5; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        reset_n = 1'b0; #1;
        check("rst_mid.busy", {31'd0, BUSY}, 32'd0);
        mhi = 32'd0; mlo = 32'd0;
        expect_regs("rst_mid", 32'd0, 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst_rel.busy", {31'd0, BUSY}, 32'd0);
        expect_regs("rst_rel", 32'd0, 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 4) == 0)
                mt(1'($urandom_range(0, 1)), ra);
            else
                run_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb,
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multi-cycle multiply/divide unit in the E stage; the responder to the MD-unit control decoder.
- Accepts the decoded START/MDU_OP/madd/HiLo/WRITE_ENABLED controls plus the E-stage operands.
- Runs multiply/divide over a fixed cycle count and holds the HI/LO architectural registers.
- Drives BUSY back to the hazard unit, which stalls dependent mfhi/mflo/mult/div instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- START  input  1  one-cycle launch pulse for an MDU operation
- MDU_OP  input  2  00 mult, 01 multu, 10 div, 11 divu
- madd  input  1  with START and MDU_OP 00/01: accumulate into {HI,LO}
- HiLo  input  1  1 selects HI, 0 selects LO (read and mthi/mtlo)
- WRITE_ENABLED  input  1  mthi/mtlo: write A to the selected register
- A  input  32  operand rs (forwarded E-stage value)
- B  input  32  operand rt (forwarded E-stage value)
- BUSY  output  1  operation in progress
- OUT  output  32  HiLo ? HI : LO, combinational from the registers

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, BUSY=0, state IDLE, counter=0, operand/result latches=0. Takes effect mid-operation too; the in-flight result is discarded.
- States:
  - IDLE: on a START edge (and not BUSY), latch A, B, MDU_OP, madd; compute the result into a pending register; load counter=MULT_CYCLES or DIV_CYCLES; go to RUN.
  - RUN: decrement the counter each edge. When the counter==1 edge occurs, commit the pending result to HI/LO and go to IDLE.
- BUSY timing:
  - BUSY=1 exactly N cycles, starting the cycle after the START edge.
  - HI/LO are updated on the edge that drops BUSY, so OUT is valid in the first BUSY=0 cycle.
- Results:
  - mult: signed 64-bit product {HI,LO} = $signed(A)*$signed(B).
  - multu: unsigned product.
  - madd/maddu: {HI,LO} = {HI,LO} + product (signed/unsigned), mod 2^64. Uses the HI/LO values at commit time.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary conditions:
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): the full DIV_CYCLES busy period still occurs; HI/LO left unchanged.
  - madd with MDU_OP 10/11: madd ignored, plain div/divu.
  - START while BUSY=1: ignored, no restart.
  - WRITE_ENABLED while BUSY=1: ignored.
  - WRITE_ENABLED and START in the same IDLE cycle: START wins; the write is dropped.
- mthi/mtlo: when WRITE_ENABLED=1 and BUSY=0, the selected register takes A on the edge; the other register is unchanged. No BUSY is generated.
- OUT: purely combinational mux of the HI/LO registers. Never shows the pending result.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: madd accumulation behaves as specified above.
- Undefined: madd input ignored; START with MDU_OP 00/01 always overwrites {HI,LO} with the product. The accumulate adder is not synthesized.

Test Plan:
- Reset: reset_n=0 mid-RUN (cycle 3 of div) -> BUSY=0 immediately; HI=LO=0; after release, OUT=0 for both HiLo values.
- mult timing: A=0xFFFFFFFE, B=3, MDU_OP=00, START pulse -> BUSY=1 for exactly 5 cycles; then HiLo=1 gives OUT=0xFFFFFFFF and HiLo=0 gives OUT=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div edge cases:
  - A=-7 (0xFFFFFFF9), B=2, div -> BUSY 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - B=0 -> HI/LO unchanged after 10 busy cycles.
- mthi/mtlo and collisions:
  - WRITE_ENABLED=1, HiLo=1, A=0x12345678 -> HI=0x12345678, LO unchanged, BUSY stays 0.
  - START pulse while BUSY -> counter unaffected; the original result commits.
  - WRITE_ENABLED during BUSY -> no change.
- madd (MDU_MADD_EN defined): HI=0, LO=0xFFFFFFFF, madd=1, MDU_OP=00, A=1, B=1 -> HI=1, LO=0. Same stimulus with the macro undefined -> HI=0, LO=1.
